// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and sync-monitor FSM encoding.
package vga_timing_pkg;

    localparam int VGA_H_TOTAL    = 800;
    localparam int VGA_H_SYNC_W   = 96;
    localparam int VGA_H_BP       = 48;
    localparam int VGA_H_ACTIVE   = 640;
    localparam int VGA_V_TOTAL    = 525;
    localparam int VGA_V_SYNC_W   = 2;
    localparam int VGA_V_BP       = 33;
    localparam int VGA_V_ACTIVE   = 480;
    localparam int VGA_LOSS_LIMIT = 3;

    localparam logic [1:0] ST_SEARCH = 2'b00;
    localparam logic [1:0] ST_ALIGN  = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_sync_monitor_sync_edge_det.sv
// Registers one active-low sync input and flags its falling edge.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic pix_ce,
    input  logic sync_n,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b1;
        end else if (pix_ce) begin
            prev <= sync_n;
        end
    end

    assign fall = pix_ce & prev & ~sync_n;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: rebuilds x/y from the syncs, locks to
// the frame and reports line-length, frame-length and display-enable errors.
module vga_sync_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int H_SYNC_W   = VGA_H_SYNC_W,
    parameter int H_BP       = VGA_H_BP,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int V_TOTAL    = VGA_V_TOTAL,
    parameter int V_SYNC_W   = VGA_V_SYNC_W,
    parameter int V_BP       = VGA_V_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int LOSS_LIMIT = VGA_LOSS_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       hsync_n,
    input  logic       vsync_n,
    input  logic       de,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       err_hlen,
    output logic       err_vlen,
    output logic       err_de,
    output logic [7:0] frame_count,
    output logic [7:0] err_count
);

    localparam logic [10:0] H_TOT = 11'(H_TOTAL);
    localparam logic [10:0] H_BEG = 11'(H_SYNC_W + H_BP);
    localparam logic [10:0] H_END = 11'(H_SYNC_W + H_BP + H_ACTIVE);
    localparam logic [10:0] H_SAT = 11'h7ff;
    localparam logic [9:0]  V_TOT = 10'(V_TOTAL);
    localparam logic [9:0]  V_BEG = 10'(V_SYNC_W + V_BP);
    localparam logic [9:0]  V_END = 10'(V_SYNC_W + V_BP + V_ACTIVE);
    localparam logic [9:0]  V_SAT = 10'h3ff;
    localparam logic [1:0]  LOSS  = 2'(LOSS_LIMIT);

    logic        hf, vf;
    logic [10:0] hcnt, hcnt_n;
    logic [9:0]  vcnt, vcnt_n;
    logic [1:0]  state, state_n;
    logic [1:0]  bad_cnt, bad_n;
    logic [7:0]  fcnt_n;
    logic        frame_bad, line_de_err;
    logic        hact, vact, act_lock;
    logic        h_eq, v_eq;
    logic        hlen_e, vlen_e, de_e, any_e, wdog;
    logic [9:0]  x_n, y_n;

    sync_edge_det u_hs_det (
        .clk    (clk),
        .reset  (reset),
        .pix_ce (pix_ce),
        .sync_n (hsync_n),
        .fall   (hf)
    );

    sync_edge_det u_vs_det (
        .clk    (clk),
        .reset  (reset),
        .pix_ce (pix_ce),
        .sync_n (vsync_n),
        .fall   (vf)
    );

    // vsync edge wins over a coincident hsync edge for the line count
    always_comb begin
        hcnt_n = hcnt;
        vcnt_n = vcnt;
        if (pix_ce) begin
            if (hf) begin
                hcnt_n = '0;
            end else if (hcnt != H_SAT) begin
                hcnt_n = hcnt + 11'd1;
            end
            if (vf) begin
                vcnt_n = '0;
            end else if (hf && (vcnt != V_SAT)) begin
                vcnt_n = vcnt + 10'd1;
            end
        end
    end

    assign h_eq   = (hcnt + 11'd1) == H_TOT;
    assign v_eq   = (vcnt + 10'd1) == V_TOT;
    assign hact   = (hcnt_n >= H_BEG) && (hcnt_n < H_END);
    assign vact   = (vcnt_n >= V_BEG) && (vcnt_n < V_END);
    assign hlen_e = hf && (state != ST_SEARCH) && !h_eq;
    assign vlen_e = vf && (state != ST_SEARCH) && !v_eq;
    assign de_e   = pix_ce && (state == ST_LOCKED)
                    && (de != (hact && vact))
                    && (hf || !line_de_err);
    assign any_e  = hlen_e | vlen_e | de_e;
    assign wdog   = pix_ce && (state != ST_SEARCH)
                    && (hcnt_n == H_SAT) && (hcnt != H_SAT);

    always_comb begin
        state_n = state;
        bad_n   = bad_cnt;
        fcnt_n  = frame_count;
        if (wdog) begin
            state_n = ST_SEARCH;
        end else if (vf) begin
            unique case (1'b1)
                (state == ST_SEARCH): begin
                    state_n = ST_ALIGN;
                end
                (state == ST_ALIGN): begin
                    if (!frame_bad && !hlen_e && v_eq) begin
                        state_n = ST_LOCKED;
                        bad_n   = '0;
                        fcnt_n  = '0;
                    end
                end
                (state == ST_LOCKED): begin
                    if (!(frame_bad || any_e)) begin
                        fcnt_n = frame_count + 8'd1;
                        bad_n  = '0;
                    end else begin
                        bad_n = bad_cnt + 2'd1;
                        if (bad_n == LOSS) begin
                            state_n = ST_SEARCH;
                        end
                    end
                end
                default: state_n = ST_SEARCH;
            endcase
        end
    end

    assign act_lock = (state_n == ST_LOCKED) && hact && vact;
    assign x_n      = act_lock ? (hcnt_n[9:0] - H_BEG[9:0]) : '0;
    assign y_n      = act_lock ? (vcnt_n - V_BEG) : '0;
    assign locked   = (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            state       <= ST_SEARCH;
            bad_cnt     <= '0;
            frame_count <= '0;
            err_count   <= '0;
            frame_bad   <= 1'b0;
            line_de_err <= 1'b0;
            pix_valid   <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
            err_de      <= 1'b0;
        end else begin
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            state       <= state_n;
            bad_cnt     <= bad_n;
            frame_count <= fcnt_n;
            frame_bad   <= vf ? 1'b0 : (frame_bad | any_e);
            line_de_err <= (hf ? 1'b0 : line_de_err) | de_e;
            frame_start <= vf;
            err_hlen    <= hlen_e;
            err_vlen    <= vlen_e;
            err_de      <= de_e;
            if (any_e || wdog) begin
                err_count <= sat_inc8(err_count);
            end
            if (pix_ce) begin
                pix_valid <= act_lock;
                x         <= x_n;
                y         <= y_n;
            end
        end
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side checker for the VGA timing interface driven by hvsync_generator (vga_h_sync, vga_v_sync, inDisplayArea).
- Re-derives pixel coordinates from the sync signals alone, locks to the frame, and flags line-length, frame-length and display-enable errors.
- Sits beside the VGA output path as an on-board self-check. Its lock and error status go to spare LEDs and the SSD score digits.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- H_SYNC_W, 96, hsync low width in pixels
- H_BP, 48, back porch in pixels, from hsync rising edge to first active pixel
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC_W, 2, vsync low width in lines
- V_BP, 33, back porch in lines
- V_ACTIVE, 480, active lines per frame
- LOSS_LIMIT, 3, consecutive bad frames before lock is dropped

Ports:
- clk  in  1  system clock; same domain as DIV_CLK
- reset  in  1  synchronous, active-high
- pix_ce  in  1  pixel clock enable; all sampling and counting happens only when this is 1
- hsync_n  in  1  horizontal sync, active-low
- vsync_n  in  1  vertical sync, active-low
- de  in  1  display enable (inDisplayArea)
- locked  out  1  monitor is aligned to the incoming frame
- pix_valid  out  1  this cycle's x/y are an active pixel
- x  out  10  active-area column, 0..H_ACTIVE-1
- y  out  10  active-area row, 0..V_ACTIVE-1
- frame_start  out  1  one-clk pulse on each vsync falling edge
- err_hlen  out  1  one-clk pulse: measured line length is not H_TOTAL
- err_vlen  out  1  one-clk pulse: measured frame length is not V_TOTAL
- err_de  out  1  one-clk pulse: de disagrees with the predicted active window
- frame_count  out  8  good frames since lock; wraps modulo 256
- err_count  out  8  total error pulses; saturates at 255

Behaviour:
- Reset:
  - All outputs are 0, the FSM is in SEARCH, and all counters are 0.
  - The previous-sync registers are set to 1, so the first low sample counts as a falling edge.
  - Reset asserted mid-frame behaves identically.
- When pix_ce=0, all state holds and all pulse outputs are 0. Outputs are registered: they reflect the sample taken on the previous pix_ce cycle.
- Edge detection:
  - An hsync falling edge (hf) is a pix_ce sample with hsync_n=0 where the previous sample was 1. A vsync falling edge (vf) is defined the same way.
- Horizontal counter hcnt (11 bits):
  - Set to 0 on hf, otherwise incremented.
  - On hf, hcnt+1 is compared with H_TOTAL; a mismatch pulses err_hlen. This check is not made in SEARCH.
  - hcnt saturates at 2047.
- Vertical counter vcnt (10 bits):
  - Set to 0 on vf. When vf and hf coincide, vf wins and vcnt=0.
  - Otherwise incremented on hf.
  - On vf, vcnt+1 is compared with V_TOTAL; a mismatch pulses err_vlen. This check is not made in SEARCH.
- Predicted window:
  - hact = hcnt in [H_SYNC_W+H_BP, H_SYNC_W+H_BP+H_ACTIVE).
  - vact = vcnt in [V_SYNC_W+V_BP, V_SYNC_W+V_BP+V_ACTIVE).
  - pix_valid = locked & hact & vact.
  - x = hcnt-(H_SYNC_W+H_BP) and y = vcnt-(V_SYNC_W+V_BP) while pix_valid; otherwise x and y are 0.
- err_de:
  - Pulses in LOCKED when de != (hact & vact).
  - At most one pulse per line: a per-line flag is cleared on hf.
- FSM states:
  - SEARCH: on vf -> ALIGN.
  - ALIGN: on the next vf, if the frame had no hlen error and its vcnt+1 equals V_TOTAL -> LOCKED (locked=1, frame_count=0). Otherwise stay in ALIGN.
  - LOCKED: on each vf, a frame with no err_* pulse is good (frame_count++, bad-frame counter cleared); otherwise the bad-frame counter is incremented. When it reaches LOSS_LIMIT -> SEARCH, locked=0.
  - Watchdog: in any state other than SEARCH, hcnt reaching 2047 (sync lost) -> SEARCH immediately and err_count increments once.
- err_count increments by 1 per clk in which any err_* pulses. Simultaneous errors in one clk count as 1.
- frame_start pulses on every vf in every state.

Decomposition:
- Package vga_timing_pkg:
  - the 640x480@60 timing constants above;
  - the FSM state encoding (SEARCH=2'b00, ALIGN=2'b01, LOCKED=2'b10);
  - shared with hvsync_generator so both ends use one source of truth.
- One natural sub-module, sync_edge_det: registers one sync input and emits its falling-edge pulse, gated by pix_ce. It is instantiated twice.

Test Plan:
- Nominal 800x525 stream with pix_ce every 4th clk, 3 frames -> locked=1 after the 2nd vf; first pix_valid at x=0,y=0 on hcnt=144,vcnt=35; last pix_valid at x=639,y=479; frame_count=1 after the 3rd vf; err_count=0.
- One line of 799 pixels while LOCKED -> single err_hlen pulse at that line's terminating hf; err_count=1; locked stays 1.
- de held high one pixel early (hcnt=143) on line 40 -> exactly one err_de pulse on that line, none on others.
- Three consecutive 524-line frames -> err_vlen pulses 3x; locked falls on the 3rd vf; FSM returns to SEARCH; re-lock after 2 good frames.
- hsync_n held high for 2100 pixels while LOCKED -> watchdog fires: locked=0, err_count+1, FSM in SEARCH.
- reset asserted for 1 clk mid-active-area -> all outputs 0 next clk; err_count=0; relock requires vf, a full frame, then vf.
